// File: rtl/pc_gen_pkg.sv
// Shared types, step sizes and the alignment helper for the fetch-stage PC generator.
package pc_pkg;

    typedef enum logic [1:0] {
        BOOT   = 2'b00,
        RUN    = 2'b01,
        HALTED = 2'b10
    } pc_state_e;

    localparam int unsigned ILEN_STEP = 4;
    localparam int unsigned CLEN_STEP = 2;

    // A target is fetchable when its low bits match the smallest instruction size.
    function automatic logic is_aligned(input logic [1:0] addr_lsb, input logic c_ext);
        logic ok;
        if (c_ext) begin
            ok = (addr_lsb[0] == 1'b0);
        end else begin
            ok = (addr_lsb == 2'b00);
        end
        return ok;
    endfunction

endpackage

// File: rtl/pc_next_sel.sv
// Combinational next-PC selection: trap > redirect > sequential advance > hold.
module pc_next_sel
    import pc_pkg::*;
#(
    parameter int XLEN  = 64,
    parameter bit C_EXT = 1'b0
) (
    input  logic [XLEN-1:0] pc_i,
    input  logic            active_i,
    input  logic            advance_i,
    input  logic            fetch_is_c_i,
    input  logic            trap_valid_i,
    input  logic [XLEN-1:0] trap_vector_i,
    input  logic            redirect_valid_i,
    input  logic [XLEN-1:0] redirect_target_i,
    output logic [XLEN-1:0] pc_plus_o,
    output logic [XLEN-1:0] pc_next_o,
    output logic            load_o,
    output logic            misalign_o
);

    logic [XLEN-1:0] step_s;
    logic [XLEN-1:0] trap_pc_s;

    // Increment and prioritised choice of the value the PC register takes next.
    always_comb begin
        if (C_EXT && fetch_is_c_i) begin
            step_s = XLEN'(CLEN_STEP);
        end else begin
            step_s = XLEN'(ILEN_STEP);
        end
        pc_plus_o  = pc_i + step_s;
        // Trap vectors are always word aligned, whatever the low bits say.
        trap_pc_s  = trap_vector_i & ~(XLEN'(3));
        pc_next_o  = pc_i;
        load_o     = 1'b0;
        misalign_o = 1'b0;
        if (!active_i) begin
            // BOOT cycle: control-flow inputs are ignored.
            load_o = 1'b0;
        end else if (trap_valid_i) begin
            pc_next_o = trap_pc_s;
            load_o    = 1'b1;
        end else if (redirect_valid_i) begin
            if (is_aligned(redirect_target_i[1:0], C_EXT)) begin
                pc_next_o = redirect_target_i;
                load_o    = 1'b1;
            end else begin
                misalign_o = 1'b1;
            end
        end else if (advance_i) begin
            pc_next_o = pc_plus_o;
            load_o    = 1'b1;
        end else begin
            load_o = 1'b0;
        end
    end

endmodule

// File: rtl/pc_gen.sv
// Fetch-stage program counter: BOOT/RUN/HALTED control, PC register and misalignment reporting.
module pc_gen
    import pc_pkg::*;
#(
    parameter int          XLEN         = 64,
    parameter logic [63:0] RESET_VECTOR = 64'h0,
    parameter bit          C_EXT        = 1'b0
) (
    input  logic            clk,
    input  logic            reset,
    output logic            fetch_valid,
    input  logic            fetch_ready,
    input  logic            fetch_is_c,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_plus,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_target,
    input  logic            trap_valid,
    input  logic [XLEN-1:0] trap_vector,
    input  logic            halt_req,
    input  logic            resume,
    output logic            halted,
    output logic            misalign_err,
    output logic [XLEN-1:0] misalign_addr
);

    pc_state_e       state_q, state_d;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] pc_next_s;
    logic            load_s;
    logic            misalign_s;
    logic            active_s;
    logic            advance_s;
    logic            misalign_err_q;
    logic [XLEN-1:0] misalign_addr_q;

    assign active_s  = (state_q != BOOT);
    assign advance_s = (state_q == RUN) && fetch_ready;

    pc_next_sel #(
        .XLEN  (XLEN),
        .C_EXT (C_EXT)
    ) u_next_sel (
        .pc_i              (pc_q),
        .active_i          (active_s),
        .advance_i         (advance_s),
        .fetch_is_c_i      (fetch_is_c),
        .trap_valid_i      (trap_valid),
        .trap_vector_i     (trap_vector),
        .redirect_valid_i  (redirect_valid),
        .redirect_target_i (redirect_target),
        .pc_plus_o         (pc_plus),
        .pc_next_o         (pc_next_s),
        .load_o            (load_s),
        .misalign_o        (misalign_s)
    );

    // Next control state; halt_req dominates resume and trap wake-up.
    always_comb begin
        state_d = state_q;
        case (state_q)
            BOOT: begin
                state_d = RUN;
            end
            RUN: begin
                if (halt_req) begin
                    state_d = HALTED;
                end else begin
                    state_d = RUN;
                end
            end
            HALTED: begin
                if (halt_req) begin
                    state_d = HALTED;
                end else if (resume || trap_valid) begin
                    state_d = RUN;
                end else begin
                    state_d = HALTED;
                end
            end
            default: begin
                state_d = BOOT;
            end
        endcase
    end

    // Control state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= BOOT;
        end else begin
            state_q <= state_d;
        end
    end

    // PC register, loaded only when the selector asks for it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q <= RESET_VECTOR[XLEN-1:0];
        end else if (load_s) begin
            pc_q <= pc_next_s;
        end
    end

    // One-cycle error pulse and the most recent rejected target.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            misalign_err_q  <= 1'b0;
            misalign_addr_q <= '0;
        end else begin
            misalign_err_q <= misalign_s;
            if (misalign_s) begin
                misalign_addr_q <= redirect_target;
            end
        end
    end

    assign pc            = pc_q;
    assign fetch_valid   = (state_q == RUN);
    assign halted        = (state_q == HALTED);
    assign misalign_err  = misalign_err_q;
    assign misalign_addr = misalign_addr_q;

endmodule

// File: tb/tb_pc_gen.sv
// Directed bench for pc_gen: three configurations share stimulus, each phase checks one of them.
module tb_pc_gen;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        fetch_ready, fetch_is_c, redirect_valid, trap_valid, halt_req, resume;
    logic [63:0] redirect_target, trap_vector;

    logic        a_fv, a_halted, a_err;
    logic [63:0] a_pc, a_pcp, a_addr;
    logic        b_fv, b_halted, b_err;
    logic [63:0] b_pc, b_pcp, b_addr;
    logic        c_fv, c_halted, c_err;
    logic [31:0] c_pc, c_pcp, c_addr;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    // A: 64-bit, compressed enabled, boots at 0x8000_0000
    pc_gen #(.XLEN(64), .RESET_VECTOR(64'h8000_0000), .C_EXT(1'b1)) u_a (
        .clk(clk), .reset(reset), .fetch_valid(a_fv), .fetch_ready(fetch_ready),
        .fetch_is_c(fetch_is_c), .pc(a_pc), .pc_plus(a_pcp),
        .redirect_valid(redirect_valid), .redirect_target(redirect_target),
        .trap_valid(trap_valid), .trap_vector(trap_vector), .halt_req(halt_req),
        .resume(resume), .halted(a_halted), .misalign_err(a_err), .misalign_addr(a_addr));

    // B: 64-bit, no compressed, boots at 0
    pc_gen #(.XLEN(64), .RESET_VECTOR(64'h0), .C_EXT(1'b0)) u_b (
        .clk(clk), .reset(reset), .fetch_valid(b_fv), .fetch_ready(fetch_ready),
        .fetch_is_c(fetch_is_c), .pc(b_pc), .pc_plus(b_pcp),
        .redirect_valid(redirect_valid), .redirect_target(redirect_target),
        .trap_valid(trap_valid), .trap_vector(trap_vector), .halt_req(halt_req),
        .resume(resume), .halted(b_halted), .misalign_err(b_err), .misalign_addr(b_addr));

    // C: 32-bit, boots one word below the top of the address space
    pc_gen #(.XLEN(32), .RESET_VECTOR(64'hFFFF_FFFC), .C_EXT(1'b0)) u_c (
        .clk(clk), .reset(reset), .fetch_valid(c_fv), .fetch_ready(fetch_ready),
        .fetch_is_c(fetch_is_c), .pc(c_pc), .pc_plus(c_pcp),
        .redirect_valid(redirect_valid), .redirect_target(redirect_target[31:0]),
        .trap_valid(trap_valid), .trap_vector(trap_vector[31:0]), .halt_req(halt_req),
        .resume(resume), .halted(c_halted), .misalign_err(c_err), .misalign_addr(c_addr));

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        fetch_ready     = 1'b0;
        fetch_is_c      = 1'b0;
        redirect_valid  = 1'b0;
        redirect_target = 64'h0;
        trap_valid      = 1'b0;
        trap_vector     = 64'h0;
        halt_req        = 1'b0;
        resume          = 1'b0;
    endtask

    initial begin
        idle();
        reset = 1'b1;

        // ---- reset and boot (A) ----
        tick();
        check_eq("rst_pc", a_pc, 64'h8000_0000);
        check_eq("rst_fv", {63'h0, a_fv}, 64'h0);
        check_eq("rst_halted", {63'h0, a_halted}, 64'h0);
        check_eq("rst_err", {63'h0, a_err}, 64'h0);
        check_eq("rst_addr", a_addr, 64'h0);
        tick();
        check_eq("rst_held_fv", {63'h0, a_fv}, 64'h0);
        reset = 1'b0;
        #1;
        check_eq("boot_fv", {63'h0, a_fv}, 64'h0);
        tick();
        check_eq("run_fv", {63'h0, a_fv}, 64'h1);
        check_eq("run_pc", a_pc, 64'h8000_0000);

        // ---- sequential fetch with a stall (A) ----
        fetch_ready = 1'b1; fetch_is_c = 1'b0;
        #1;
        check_eq("pcp_4", a_pcp, 64'h8000_0004);
        tick();
        check_eq("seq_4", a_pc, 64'h8000_0004);
        fetch_ready = 1'b0; fetch_is_c = 1'b1;
        tick();
        check_eq("stall", a_pc, 64'h8000_0004);
        fetch_ready = 1'b1;
        #1;
        check_eq("pcp_2", a_pcp, 64'h8000_0006);
        tick();
        check_eq("seq_c", a_pc, 64'h8000_0006);
        idle();

        // ---- trap beats redirect, vector low bits cleared (A) ----
        trap_valid = 1'b1; trap_vector = 64'h103;
        redirect_valid = 1'b1; redirect_target = 64'h200;
        tick();
        check_eq("trap_prio_pc", a_pc, 64'h100);
        check_eq("trap_prio_err", {63'h0, a_err}, 64'h0);
        idle();

        // ---- halt / redirect while halted / resume / trap wake (A) ----
        halt_req = 1'b1;
        tick();
        check_eq("halt_fv", {63'h0, a_fv}, 64'h0);
        check_eq("halt_h", {63'h0, a_halted}, 64'h1);
        check_eq("halt_pc", a_pc, 64'h100);
        halt_req = 1'b0; redirect_valid = 1'b1; redirect_target = 64'h40;
        tick();
        check_eq("hredir_pc", a_pc, 64'h40);
        check_eq("hredir_h", {63'h0, a_halted}, 64'h1);
        redirect_valid = 1'b0; resume = 1'b1;
        tick();
        check_eq("resume_fv", {63'h0, a_fv}, 64'h1);
        check_eq("resume_h", {63'h0, a_halted}, 64'h0);
        check_eq("resume_pc", a_pc, 64'h40);
        resume = 1'b0; halt_req = 1'b1;
        tick();
        check_eq("halt2_h", {63'h0, a_halted}, 64'h1);
        resume = 1'b1;
        tick();
        check_eq("halt_and_resume_h", {63'h0, a_halted}, 64'h1);
        idle();
        trap_valid = 1'b1; trap_vector = 64'h500;
        tick();
        check_eq("twake_fv", {63'h0, a_fv}, 64'h1);
        check_eq("twake_pc", a_pc, 64'h500);
        idle();

        // ---- async reset, then misalignment handling (B) ----
        reset = 1'b1;
        #1;
        check_eq("async_rst_pc", a_pc, 64'h8000_0000);
        check_eq("async_rst_fv", {63'h0, a_fv}, 64'h0);
        tick();
        reset = 1'b0;
        redirect_valid = 1'b1; redirect_target = 64'h300;
        tick();
        check_eq("boot_ignore_pc", b_pc, 64'h0);
        check_eq("boot_ignore_fv", {63'h0, b_fv}, 64'h1);
        redirect_target = 64'h202;
        tick();
        check_eq("mis_pc", b_pc, 64'h0);
        check_eq("mis_err", {63'h0, b_err}, 64'h1);
        check_eq("mis_addr", b_addr, 64'h202);
        redirect_target = 64'h206;
        tick();
        check_eq("mis2_err", {63'h0, b_err}, 64'h1);
        check_eq("mis2_addr", b_addr, 64'h206);
        check_eq("mis2_pc", b_pc, 64'h0);
        redirect_target = 64'h300;
        tick();
        check_eq("ok_pc", b_pc, 64'h300);
        check_eq("ok_err", {63'h0, b_err}, 64'h0);
        check_eq("ok_addr_held", b_addr, 64'h206);
        redirect_target = 64'h402;
        tick();
        check_eq("mis3_err", {63'h0, b_err}, 64'h1);
        check_eq("mis3_pc", b_pc, 64'h300);
        #1;
        reset = 1'b1;
        #1;
        check_eq("midrst_pc", b_pc, 64'h0);
        check_eq("midrst_err", {63'h0, b_err}, 64'h0);
        check_eq("midrst_addr", b_addr, 64'h0);
        check_eq("midrst_fv", {63'h0, b_fv}, 64'h0);
        idle();
        tick();
        check_eq("midrst_held_err", {63'h0, b_err}, 64'h0);

        // ---- 32-bit wrap (C) ----
        reset = 1'b0;
        tick();
        check_eq("c_run_fv", {63'h0, c_fv}, 64'h1);
        check_eq("c_pc", {32'h0, c_pc}, 64'hFFFF_FFFC);
        fetch_ready = 1'b1;
        #1;
        check_eq("c_pcp_wrap", {32'h0, c_pcp}, 64'h0);
        tick();
        check_eq("c_wrap_pc", {32'h0, c_pc}, 64'h0);
        check_eq("c_pcp_4", {32'h0, c_pcp}, 64'h4);
        idle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
